// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mcu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WB,
    ST_FAULT
  } state_t;

  // Instruction classes that drive the state sequence after DECODE.
  typedef enum logic [2:0] {
    CL_ALU,     // R-type and CLO/CLZ: EXECUTE -> WB
    CL_LOAD,    // EXECUTE -> MEM -> WB
    CL_STORE,   // EXECUTE -> MEM
    CL_BRANCH,  // EXECUTE only
    CL_JUMP     // EXECUTE only
  } iclass_t;

  localparam int unsigned FNC_W = 5;

  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BLEZ     = 6'b000110;
  localparam logic [5:0] OP_BGTZ     = 6'b000111;
  localparam logic [5:0] OP_LB       = 6'b100000;
  localparam logic [5:0] OP_LH       = 6'b100001;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_LHU      = 6'b100101;
  localparam logic [5:0] OP_SB       = 6'b101000;
  localparam logic [5:0] OP_SH       = 6'b101001;
  localparam logic [5:0] OP_SW       = 6'b101011;

  localparam logic [FNC_W-1:0] FNC_RTYPE = 5'b00000;
  localparam logic [FNC_W-1:0] FNC_CLZ   = 5'b00001;
  localparam logic [FNC_W-1:0] FNC_LW    = 5'b01000;
  localparam logic [FNC_W-1:0] FNC_LHU   = 5'b01001;
  localparam logic [FNC_W-1:0] FNC_LB    = 5'b01010;
  localparam logic [FNC_W-1:0] FNC_LH    = 5'b01011;
  localparam logic [FNC_W-1:0] FNC_SW    = 5'b01101;
  localparam logic [FNC_W-1:0] FNC_SH    = 5'b01110;
  localparam logic [FNC_W-1:0] FNC_SB    = 5'b01111;
  localparam logic [FNC_W-1:0] FNC_BEQ   = 5'b10000;
  localparam logic [FNC_W-1:0] FNC_BGTZ  = 5'b10101;
  localparam logic [FNC_W-1:0] FNC_BLEZ  = 5'b10110;
  localparam logic [FNC_W-1:0] FNC_J     = 5'b00000;

endpackage

// File: rtl/mcycle_control_if.sv
// Control-unit <-> datapath/RAM signal bundle.
interface mcycle_control_if #(
  parameter int unsigned ALU_FNC_W = 5,
  parameter int unsigned HILO_W    = 2
);

  logic [5:0]           opcode;
  logic                 MOC;
  logic                 reg_dst;
  logic                 mem_to_reg;
  logic                 alu_src;
  logic                 reg_write;
  logic                 jump;
  logic                 branch;
  logic                 MOV;
  logic [ALU_FNC_W-1:0] alu_fnc;
  logic [HILO_W-1:0]    HILO;
  logic                 RAMEnable;
  logic                 RW;
  logic                 ir_load;
  logic                 pc_write;
  logic                 busy;
  logic                 illegal;
  logic                 fault;

  modport master (
    input  opcode, MOC,
    output reg_dst, mem_to_reg, alu_src, reg_write, jump, branch, MOV,
           alu_fnc, HILO, RAMEnable, RW, ir_load, pc_write, busy, illegal, fault
  );

  modport slave (
    output opcode, MOC,
    input  reg_dst, mem_to_reg, alu_src, reg_write, jump, branch, MOV,
           alu_fnc, HILO, RAMEnable, RW, ir_load, pc_write, busy, illegal, fault
  );

endinterface

// File: rtl/mcu_decode.sv
// Combinational opcode lookup: instruction class, ALU function, ALU source, legality.
module mcu_decode
  import mcu_pkg::*;
(
  input  logic [5:0]       op,
  output iclass_t          iclass,
  output logic [FNC_W-1:0] fnc,
  output logic             alu_src,
  output logic             legal
);

  // Table lookup; anything not listed is undecodable.
  always_comb begin
    iclass  = CL_ALU;
    fnc     = '0;
    alu_src = 1'b1;
    legal   = 1'b1;
    case (op)
      OP_RTYPE:    begin iclass = CL_ALU;    fnc = FNC_RTYPE; alu_src = 1'b0; end
      OP_SPECIAL2: begin iclass = CL_ALU;    fnc = FNC_CLZ;   alu_src = 1'b0; end
      OP_LW:       begin iclass = CL_LOAD;   fnc = FNC_LW;   end
      OP_LHU:      begin iclass = CL_LOAD;   fnc = FNC_LHU;  end
      OP_LB:       begin iclass = CL_LOAD;   fnc = FNC_LB;   end
      OP_LH:       begin iclass = CL_LOAD;   fnc = FNC_LH;   end
      OP_SW:       begin iclass = CL_STORE;  fnc = FNC_SW;   end
      OP_SH:       begin iclass = CL_STORE;  fnc = FNC_SH;   end
      OP_SB:       begin iclass = CL_STORE;  fnc = FNC_SB;   end
      OP_BEQ:      begin iclass = CL_BRANCH; fnc = FNC_BEQ;  end
      OP_BGTZ:     begin iclass = CL_BRANCH; fnc = FNC_BGTZ; end
      OP_BLEZ:     begin iclass = CL_BRANCH; fnc = FNC_BLEZ; end
      OP_J:        begin iclass = CL_JUMP;   fnc = FNC_J;    end
      default:     begin legal = 1'b0; alu_src = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mcycle_control.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXECUTE/MEM/WB with a bounded
// RAMEnable/MOC handshake and a sticky FAULT state on MOC timeout.
module mcycle_control
  import mcu_pkg::*;
#(
  parameter int unsigned ALU_FNC_W   = 5,
  parameter int unsigned MOC_TIMEOUT = 16,
  parameter int unsigned HILO_W      = 2
) (
  input logic              clk,
  input logic              reset,
  mcycle_control_if.master bus
);

  localparam int unsigned      CW       = $clog2(MOC_TIMEOUT);
  localparam logic [CW-1:0]    CNT_LAST = CW'(MOC_TIMEOUT - 1);

  state_t           state;
  logic [5:0]       op_q;
  logic [CW-1:0]    wait_cnt;

  logic [5:0]       dec_op;
  iclass_t          dec_class;
  logic [FNC_W-1:0] dec_fnc;
  logic             dec_alu_src;
  logic             dec_legal;

  // DECODE judges the live opcode (the register captures it only at the end
  // of DECODE); every later state works from the latched copy.
  assign dec_op = (state == ST_DECODE) ? bus.opcode : op_q;

  mcu_decode u_decode (
    .op      (dec_op),
    .iclass  (dec_class),
    .fnc     (dec_fnc),
    .alu_src (dec_alu_src),
    .legal   (dec_legal)
  );

  // State sequencing, opcode latch and MOC wait counter.
  // The counter only moves while a memory state waits and is cleared on the
  // completing edge, so it is already zero on every entry to FETCH or MEM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_FETCH;
      op_q     <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_FETCH, ST_MEM: begin
          if (bus.MOC) begin
            wait_cnt <= '0;
            if (state == ST_FETCH)
              state <= ST_DECODE;
            else if (dec_class == CL_LOAD)
              state <= ST_WB;
            else
              state <= ST_FETCH;
          end else if (wait_cnt == CNT_LAST) begin
            state <= ST_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DECODE: begin
          op_q  <= bus.opcode;
          state <= dec_legal ? ST_EXECUTE : ST_FETCH;
        end
        ST_EXECUTE: begin
          case (dec_class)
            CL_LOAD, CL_STORE: state <= ST_MEM;
            CL_ALU:            state <= ST_WB;
            default:           state <= ST_FETCH;
          endcase
        end
        ST_WB:    state <= ST_FETCH;
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_FETCH;
      endcase
    end
  end

  // Output decode from state and latched opcode; everything held low in reset.
  // The fetch pulses are qualified with MOC so they fire only on the completing cycle.
  always_comb begin
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src    = 1'b0;
    bus.reg_write  = 1'b0;
    bus.jump       = 1'b0;
    bus.branch     = 1'b0;
    bus.MOV        = 1'b0;
    bus.alu_fnc    = '0;
    bus.HILO       = {HILO_W{1'b0}};
    bus.RAMEnable  = 1'b0;
    bus.RW         = 1'b0;
    bus.ir_load    = 1'b0;
    bus.pc_write   = 1'b0;
    bus.busy       = 1'b0;
    bus.illegal    = 1'b0;
    bus.fault      = 1'b0;
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          bus.RAMEnable = 1'b1;
          bus.RW        = 1'b1;
          bus.ir_load   = bus.MOC;
          bus.pc_write  = bus.MOC;
        end
        ST_DECODE: begin
          bus.busy    = 1'b1;
          bus.illegal = ~dec_legal;
        end
        ST_EXECUTE: begin
          bus.busy     = 1'b1;
          bus.alu_src  = dec_alu_src;
          bus.alu_fnc  = ALU_FNC_W'(dec_fnc);
          bus.jump     = (dec_class == CL_JUMP);
          bus.branch   = (dec_class == CL_BRANCH);
          bus.pc_write = (dec_class == CL_JUMP) || (dec_class == CL_BRANCH);
        end
        ST_MEM: begin
          bus.busy      = 1'b1;
          bus.RAMEnable = 1'b1;
          bus.RW        = (dec_class == CL_LOAD);
        end
        ST_WB: begin
          bus.busy       = 1'b1;
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = (dec_class == CL_LOAD);
          bus.reg_dst    = (dec_class == CL_ALU);
        end
        ST_FAULT: bus.fault = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_control.sv
// Scoreboard bench for mcycle_control: the driver expands each instruction into
// its expected per-cycle output trace from the opcode table and timing rules;
// a negedge monitor pops and compares one entry per cycle.
module tb_mcycle_control;

  localparam int unsigned T = 16;

  localparam int K_ALU = 0;
  localparam int K_LD  = 1;
  localparam int K_ST  = 2;
  localparam int K_BR  = 3;
  localparam int K_J   = 4;

  typedef struct packed {
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
    logic       branch;
    logic       mov;
    logic [4:0] alu_fnc;
    logic [1:0] hilo;
    logic       ram;
    logic       rw;
    logic       ir_load;
    logic       pc_write;
    logic       busy;
    logic       illegal;
    logic       fault;
  } outs_t;

  typedef struct {
    outs_t v;
    bit    skip;
    string tag;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   n_tests;
  int   n_fail;
  outs_t act;

  mcycle_control_if #(.ALU_FNC_W(5), .HILO_W(2)) bus ();

  mcycle_control #(
    .ALU_FNC_W   (5),
    .MOC_TIMEOUT (T),
    .HILO_W      (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    act            = '0;
    act.reg_dst    = bus.reg_dst;
    act.mem_to_reg = bus.mem_to_reg;
    act.alu_src    = bus.alu_src;
    act.reg_write  = bus.reg_write;
    act.jump       = bus.jump;
    act.branch     = bus.branch;
    act.mov        = bus.MOV;
    act.alu_fnc    = bus.alu_fnc;
    act.hilo       = bus.HILO;
    act.ram        = bus.RAMEnable;
    act.rw         = bus.RW;
    act.ir_load    = bus.ir_load;
    act.pc_write   = bus.pc_write;
    act.busy       = bus.busy;
    act.illegal    = bus.illegal;
    act.fault      = bus.fault;
  end

  // Monitor: one expected entry per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (!e.skip) begin
        n_tests++;
        if (act !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %06h expected %06h (t=%0t)", e.tag, act, e.v, $time);
        end
      end
    end
  end

  // Reference opcode table.
  function automatic void ref_info(input logic [5:0] op, output int cls,
                                   output logic [4:0] fnc, output bit legal);
    legal = 1'b1;
    cls   = K_ALU;
    fnc   = 5'b00000;
    case (op)
      6'b000000: begin cls = K_ALU; fnc = 5'b00000; end
      6'b011100: begin cls = K_ALU; fnc = 5'b00001; end
      6'b100011: begin cls = K_LD;  fnc = 5'b01000; end
      6'b100101: begin cls = K_LD;  fnc = 5'b01001; end
      6'b100000: begin cls = K_LD;  fnc = 5'b01010; end
      6'b100001: begin cls = K_LD;  fnc = 5'b01011; end
      6'b101011: begin cls = K_ST;  fnc = 5'b01101; end
      6'b101001: begin cls = K_ST;  fnc = 5'b01110; end
      6'b101000: begin cls = K_ST;  fnc = 5'b01111; end
      6'b000100: begin cls = K_BR;  fnc = 5'b10000; end
      6'b000111: begin cls = K_BR;  fnc = 5'b10101; end
      6'b000110: begin cls = K_BR;  fnc = 5'b10110; end
      6'b000010: begin cls = K_J;   fnc = 5'b00000; end
      default:   legal = 1'b0;
    endcase
  endfunction

  function automatic logic [5:0] junk();
    return 6'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock of stimulus plus its expected outputs.
  task automatic drive(input bit rst, input logic moc, input logic [5:0] op,
                       input outs_t e, input bit skip, input string tag);
    exp_t x;
    reset      = rst;
    bus.MOC    = moc;
    bus.opcode = op;
    x.v    = e;
    x.skip = skip;
    x.tag  = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // First reset cycle may still show pre-reset outputs; later ones must be zero.
  task automatic do_reset(input int n);
    drive(1'b1, rbit(), junk(), '0, 1'b1, "rst.first");
    for (int i = 1; i < n; i++)
      drive(1'b1, rbit(), junk(), '0, 1'b0, "rst.hold");
  endtask

  // One RAM access: w wait cycles before MOC; w >= T times out into FAULT.
  // abort_at >= 0 asserts reset in that wait cycle instead.
  task automatic access(input string nm, input bit rd, input bit is_fetch,
                        input int w, input int abort_at, output bit ended);
    outs_t e;
    ended = 1'b0;
    for (int i = 0; i < w && i < int'(T); i++) begin
      if (i == abort_at) begin
        do_reset(2);
        ended = 1'b1;
        return;
      end
      e = '0; e.busy = !is_fetch; e.ram = 1'b1; e.rw = rd;
      drive(1'b0, 1'b0, junk(), e, 1'b0, {nm, ".wait"});
    end
    if (w >= int'(T)) begin
      for (int i = 0; i < 4; i++) begin
        e = '0; e.fault = 1'b1;
        drive(1'b0, rbit(), junk(), e, 1'b0, {nm, ".fault"});
      end
      do_reset(2);
      ended = 1'b1;
      return;
    end
    e = '0; e.busy = !is_fetch; e.ram = 1'b1; e.rw = rd;
    e.ir_load = is_fetch; e.pc_write = is_fetch;
    drive(1'b0, 1'b1, junk(), e, 1'b0, {nm, ".done"});
  endtask

  task automatic run_instr(input logic [5:0] op, input int wf, input int wm,
                           input int abort_at);
    int         cls;
    logic [4:0] fnc;
    bit         legal;
    bit         ended;
    outs_t      e;
    string      nm;
    ref_info(op, cls, fnc, legal);
    nm = $sformatf("op%02h", op);

    access({nm, ".fetch"}, 1'b1, 1'b1, wf, -1, ended);
    if (ended) return;

    e = '0; e.busy = 1'b1; e.illegal = !legal;
    drive(1'b0, rbit(), op, e, 1'b0, {nm, ".decode"});
    if (!legal) return;

    e = '0; e.busy = 1'b1; e.alu_src = (cls != K_ALU); e.alu_fnc = fnc;
    e.jump = (cls == K_J); e.branch = (cls == K_BR);
    e.pc_write = (cls == K_J) || (cls == K_BR);
    drive(1'b0, rbit(), junk(), e, 1'b0, {nm, ".exec"});
    if (cls == K_J || cls == K_BR) return;

    if (cls == K_LD || cls == K_ST) begin
      access({nm, ".mem"}, (cls == K_LD), 1'b0, wm, abort_at, ended);
      if (ended || cls == K_ST) return;
    end

    e = '0; e.busy = 1'b1; e.reg_write = 1'b1;
    e.mem_to_reg = (cls == K_LD); e.reg_dst = (cls == K_ALU);
    drive(1'b0, rbit(), junk(), e, 1'b0, {nm, ".wb"});
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return int'(T) - 1;
    if (r == 1) return int'(T);
    return int'($urandom_range(0, 2));
  endfunction

  logic [5:0] legal_ops [13];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    legal_ops = '{6'b000000, 6'b011100, 6'b100011, 6'b100101, 6'b100000,
                  6'b100001, 6'b101011, 6'b101001, 6'b101000, 6'b000100,
                  6'b000111, 6'b000110, 6'b000010};
    reset      = 1'b1;
    bus.MOC    = 1'b0;
    bus.opcode = '0;
    @(posedge clk);
    #1;
    do_reset(3);

    // Directed cases.
    run_instr(6'b000000, 0, 0, -1);            // ADD, 4 cycles
    run_instr(6'b100011, 0, 3, -1);            // LW with 3 MEM waits, 8 cycles
    run_instr(6'b101000, 0, 0, -1);            // SB
    run_instr(6'b000110, 0, 0, -1);            // BLEZ, 3 cycles
    run_instr(6'b111111, 0, 0, -1);            // illegal
    run_instr(6'b000000, int'(T), 0, -1);      // fetch timeout -> sticky fault
    run_instr(6'b101011, 0, 5, 2);             // SW aborted by reset in MEM
    run_instr(6'b100001, int'(T) - 1, int'(T) - 1, -1); // completion wins at limit
    run_instr(6'b101001, 1, int'(T), -1);      // MEM timeout -> fault
    run_instr(6'b000010, 2, 0, -1);            // J
    run_instr(6'b011100, 0, 0, -1);            // CLO/CLZ

    // Randomized instruction stream.
    for (int n = 0; n < 120; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 9) == 0)
        op = junk();
      else
        op = legal_ops[$urandom_range(0, 12)];
      run_instr(op, pick_wait(), pick_wait(), -1);
    end

    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
